perf_trace_axis_streamer: RTL and testbench



---
 rtl/perf_trace_axis_streamer.sv | 131 +++++++++++++
 tb/tb_perf_trace_axis_streamer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/perf_trace_axis_streamer.sv
// perf_trace_axis_streamer
// Trace-capture front end: per-event modular counters with sticky wrap flags,
// a packet queue that snapshots payload/overflow/counters on each write, an
// AXI4-Stream master draining that queue, and an edge detector for the
// GPIO-driven control write strobe.

module perf_trace_axis_streamer #(
  parameter int NUM_EVENTS    = 39,
  parameter int COUNTER_WIDTH = 7,
  parameter int PAYLOAD_WIDTH = 128,
  parameter int FIFO_DEPTH    = 16,
  localparam int DATA_WIDTH   = PAYLOAD_WIDTH + NUM_EVENTS * (COUNTER_WIDTH + 1)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                ctrl_we,
  output logic                                ctrl_we_pos_edge,
  output logic                                ctrl_we_neg_edge,
  input  logic [NUM_EVENTS-1:0]               events,
  output logic [NUM_EVENTS*COUNTER_WIDTH-1:0] counters,
  output logic [NUM_EVENTS-1:0]               overflow_map,
  input  logic                                write_enable,
  input  logic [PAYLOAD_WIDTH-1:0]            payload,
  input  logic                                tlast_in,
  input  logic [31:0]                         tlast_interval,
  output logic                                M_AXIS_tvalid,
  input  logic                                M_AXIS_tready,
  output logic [DATA_WIDTH-1:0]               M_AXIS_tdata,
  output logic                                M_AXIS_tlast,
  output logic                                dropped
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_BITS = NUM_EVENTS * COUNTER_WIDTH;

  // Each queue entry carries the packet plus its tlast bit in the MSB.
  logic                                weQ;
  logic [CNT_BITS-1:0]                 cntQ;
  logic [NUM_EVENTS-1:0]               ovfQ;
  logic [DATA_WIDTH:0]                 memQ [FIFO_DEPTH];
  logic [AW-1:0]                       wrPtrQ, rdPtrQ;
  logic [AW:0]                         countQ, countD;
  logic [31:0]                         frameCountQ;
  logic                                droppedQ;

  logic [DATA_WIDTH-1:0]               packetD;
  logic                                packetLastD;
  logic                                fullD, emptyD, popD, pushD;

  // Edge pulses are combinational so they line up with the strobe change.
  always_comb begin
    ctrl_we_pos_edge = ctrl_we & ~weQ;
    ctrl_we_neg_edge = ~ctrl_we & weQ;
  end

  // Remember last cycle's strobe level for the edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) weQ <= 1'b0;
    else        weQ <= ctrl_we;
  end

  // A write restarts every counter at this cycle's event bit; otherwise count and flag wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntQ <= '0;
      ovfQ <= '0;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        if (write_enable) begin
          cntQ[i*COUNTER_WIDTH +: COUNTER_WIDTH] <= {{(COUNTER_WIDTH-1){1'b0}}, events[i]};
          ovfQ[i] <= 1'b0;
        end else if (events[i]) begin
          cntQ[i*COUNTER_WIDTH +: COUNTER_WIDTH] <= cntQ[i*COUNTER_WIDTH +: COUNTER_WIDTH] + 1'b1;
          if (&cntQ[i*COUNTER_WIDTH +: COUNTER_WIDTH]) ovfQ[i] <= 1'b1;
        end
      end
    end
  end

  // Packet snapshot uses pre-update counter values; tlast from caller or frame interval.
  always_comb begin
    packetD     = {payload, ovfQ, cntQ};
    packetLastD = tlast_in | ((tlast_interval != 32'd0) && (frameCountQ + 32'd1 == tlast_interval));
    emptyD      = (countQ == '0);
    fullD       = (countQ == (AW+1)'(FIFO_DEPTH));
    popD        = ~emptyD & M_AXIS_tready;
    pushD       = write_enable & (~fullD | popD);
    countD      = countQ;
    if (pushD && !popD)      countD = countQ + 1'b1;
    else if (!pushD && popD) countD = countQ - 1'b1;
  end

  // Queue storage and pointers; a full queue still accepts a push when it is popped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < FIFO_DEPTH; j++) memQ[j] <= '0;
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      if (pushD) begin
        memQ[wrPtrQ] <= {packetLastD, packetD};
        wrPtrQ       <= wrPtrQ + 1'b1;
      end
      if (popD) rdPtrQ <= rdPtrQ + 1'b1;
      countQ <= countD;
    end
  end

  // Frame position advances only on accepted packets; lost writes raise the sticky drop flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameCountQ <= '0;
      droppedQ    <= 1'b0;
    end else begin
      if (pushD) frameCountQ <= packetLastD ? 32'd0 : frameCountQ + 32'd1;
      if (write_enable && !pushD) droppedQ <= 1'b1;
    end
  end

  // Stream side presents the queue head, holding it until the consumer accepts it.
  always_comb begin
    counters      = cntQ;
    overflow_map  = ovfQ;
    M_AXIS_tvalid = ~emptyD;
    M_AXIS_tdata  = memQ[rdPtrQ][DATA_WIDTH-1:0];
    M_AXIS_tlast  = ~emptyD & memQ[rdPtrQ][DATA_WIDTH];
    dropped       = droppedQ;
  end

endmodule

// File: tb/tb_perf_trace_axis_streamer.sv
// Directed self-checking bench for perf_trace_axis_streamer.

module tb_perf_trace_axis_streamer;

  localparam int NE = 39;
  localparam int CW = 7;
  localparam int PW = 128;
  localparam int FD = 16;
  localparam int DW = PW + NE * (CW + 1);

  logic            clk = 1'b0;
  logic            rst_n;
  logic            ctrl_we;
  logic            ctrl_we_pos_edge, ctrl_we_neg_edge;
  logic [NE-1:0]   events;
  logic [NE*CW-1:0] counters;
  logic [NE-1:0]   overflow_map;
  logic            write_enable;
  logic [PW-1:0]   payload;
  logic            tlast_in;
  logic [31:0]     tlast_interval;
  logic            tvalid, tready, tlast;
  logic [DW-1:0]   tdata;
  logic            dropped;

  int checks = 0;
  int failures = 0;

  perf_trace_axis_streamer #(
    .NUM_EVENTS(NE), .COUNTER_WIDTH(CW), .PAYLOAD_WIDTH(PW), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ctrl_we(ctrl_we), .ctrl_we_pos_edge(ctrl_we_pos_edge), .ctrl_we_neg_edge(ctrl_we_neg_edge),
    .events(events), .counters(counters), .overflow_map(overflow_map),
    .write_enable(write_enable), .payload(payload), .tlast_in(tlast_in),
    .tlast_interval(tlast_interval),
    .M_AXIS_tvalid(tvalid), .M_AXIS_tready(tready), .M_AXIS_tdata(tdata),
    .M_AXIS_tlast(tlast), .dropped(dropped)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic [PW-1:0] pl, input logic tl);
    write_enable = we;
    payload      = pl;
    tlast_in     = tl;
    tick();
    write_enable = 1'b0;
    tlast_in     = 1'b0;
  endtask

  task automatic applyReset();
    rst_n          = 1'b0;
    ctrl_we        = 1'b0;
    events         = '0;
    write_enable   = 1'b0;
    payload        = '0;
    tlast_in       = 1'b0;
    tlast_interval = '0;
    tready         = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  logic [NE*CW-1:0] expCnt;
  logic [DW-1:0]    expPkt;
  logic [PW-1:0]    pl;
  logic [6:0]       expLast;
  logic [4:0]       weSeq;

  initial begin
    applyReset();
    checkOutput("reset_tvalid", tvalid, 1'b0);
    checkOutput("reset_tlast", tlast, 1'b0);
    checkOutput("reset_counters", counters, '0);
    checkOutput("reset_overflow", overflow_map, '0);
    checkOutput("reset_dropped", dropped, 1'b0);
    checkOutput("reset_pos_edge", ctrl_we_pos_edge, 1'b0);
    checkOutput("reset_neg_edge", ctrl_we_neg_edge, 1'b0);

    // Edge detector: ctrl_we 0,1,1,1,0 over five cycles.
    weSeq = 5'b01110;
    for (int k = 0; k < 5; k++) begin
      ctrl_we = weSeq[4-k];
      #1;
      checkOutput($sformatf("pos_edge_c%0d", k+1), ctrl_we_pos_edge, (k == 1));
      checkOutput($sformatf("neg_edge_c%0d", k+1), ctrl_we_neg_edge, (k == 4));
      tick();
    end
    ctrl_we = 1'b0;

    // Counter wrap: 130 events on counter 3 -> 2 with overflow set.
    applyReset();
    events = 39'd1 << 3;
    repeat (130) tick();
    events = '0;
    expCnt = '0;
    expCnt[3*CW +: CW] = 7'd2;
    checkOutput("wrap_counter3", counters[3*CW +: CW], 7'd2);
    checkOutput("wrap_all_counters", counters, expCnt);
    checkOutput("wrap_overflow", overflow_map, 39'd8);

    // Packet capture of the wrapped state, then counters/flags clear.
    pl = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_0F1E_2D3C;
    expPkt = {pl, 39'd8, expCnt};
    applyStimulus(1'b1, pl, 1'b0);
    checkOutput("pkt_tvalid", tvalid, 1'b1);
    checkOutput("pkt_tdata", tdata, expPkt);
    checkOutput("pkt_tlast", tlast, 1'b0);
    checkOutput("pkt_counters_cleared", counters, '0);
    checkOutput("pkt_overflow_cleared", overflow_map, '0);
    tready = 1'b1;
    tick();
    tready = 1'b0;
    checkOutput("pkt_popped", tvalid, 1'b0);

    // Write with a concurrent event on counter 0 at value 5.
    applyReset();
    events = 39'd1;
    repeat (5) tick();
    checkOutput("conc_pre_counter0", counters[CW-1:0], 7'd5);
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    events = '0;
    checkOutput("conc_live_counter0", counters[CW-1:0], 7'd1);
    checkOutput("conc_packet_counter0", tdata[CW-1:0], 7'd5);
    checkOutput("conc_overflow", overflow_map, '0);

    // Interval framing, first with interval only, then with tlast_in on packet 2.
    for (int pass = 0; pass < 2; pass++) begin
      applyReset();
      tlast_interval = 32'd3;
      tready = 1'b1;
      expLast = (pass == 0) ? 7'b0100100 : 7'b0010010;
      for (int k = 0; k < 7; k++) begin
        applyStimulus(1'b1, PW'(k + 1), (pass == 1) && (k == 1));
        checkOutput($sformatf("frame%0d_pkt%0d_tvalid", pass, k+1), tvalid, 1'b1);
        checkOutput($sformatf("frame%0d_pkt%0d_tlast", pass, k+1), tlast, expLast[k]);
        checkOutput($sformatf("frame%0d_pkt%0d_payload", pass, k+1), tdata[DW-1 -: PW], PW'(k + 1));
      end
      tick();
      checkOutput($sformatf("frame%0d_drained", pass), tvalid, 1'b0);
    end

    // Backpressure: FD+2 writes into a stalled stream, then drain.
    applyReset();
    for (int k = 0; k < FD + 2; k++) begin
      applyStimulus(1'b1, PW'(k + 1), 1'b0);
      checkOutput($sformatf("bp_w%0d_tvalid", k), tvalid, 1'b1);
      checkOutput($sformatf("bp_w%0d_head", k), tdata[DW-1 -: PW], PW'(1));
      if (k == FD - 1) checkOutput("bp_not_dropped_at_full", dropped, 1'b0);
    end
    checkOutput("bp_dropped", dropped, 1'b1);
    tready = 1'b1;
    for (int k = 0; k < FD; k++) begin
      checkOutput($sformatf("bp_pop%0d_tvalid", k), tvalid, 1'b1);
      checkOutput($sformatf("bp_pop%0d_payload", k), tdata[DW-1 -: PW], PW'(k + 1));
      tick();
    end
    checkOutput("bp_empty_after_drain", tvalid, 1'b0);
    tready = 1'b0;

    // Asynchronous reset with queued data, wrapped counters and a drop recorded.
    applyReset();
    for (int k = 0; k < FD + 1; k++) applyStimulus(1'b1, PW'(k + 100), 1'b0);
    events = '1;
    repeat (130) tick();
    events = '0;
    checkOutput("areset_pre_tvalid", tvalid, 1'b1);
    checkOutput("areset_pre_dropped", dropped, 1'b1);
    checkOutput("areset_pre_overflow", overflow_map, {NE{1'b1}});
    checkOutput("areset_pre_counter7", counters[7*CW +: CW], 7'd2);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("areset_tvalid", tvalid, 1'b0);
    checkOutput("areset_counters", counters, '0);
    checkOutput("areset_overflow", overflow_map, '0);
    checkOutput("areset_dropped", dropped, 1'b0);
    checkOutput("areset_tlast", tlast, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
